// File: rtl/exp_taylor_accel_pkg.sv
// Shared types and constants for the Taylor-series e^x accelerator:
// FSM state encoding, reciprocal constant generator and term-count limits.
package exp_taylor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_X,
    MUL_R,
    ACC,
    FIN
  } state_t;

  localparam int N_TERMS_MIN = 2;
  localparam int N_TERMS_MAX = 16;

  function automatic bit n_terms_ok(input int n);
    return (n >= N_TERMS_MIN) && (n <= N_TERMS_MAX);
  endfunction

  // floor(2^frac_w / k); k=0 never addressed, returns 0
  function automatic logic [31:0] recip(input int k, input int frac_w);
    if (k <= 0) return '0;
    return (32'd1 << frac_w) / 32'(k);
  endfunction

endpackage

// File: rtl/exp_taylor_accel_if.sv
// Start/done handshake plus result-buffer write port of the e^x accelerator.
interface exp_taylor_accel_if #(
  parameter int INT_W  = 2,
  parameter int FRAC_W = 16,
  parameter int OUT_W  = 22
);

  logic              start;
  logic [INT_W-1:0]  int_in;
  logic [FRAC_W-1:0] frac_in;
  logic              stream;
  logic              busy;
  logic              wr_req;
  logic [OUT_W-1:0]  wr_data;
  logic              done;
  logic              ovf;

  modport master (
    output start, int_in, frac_in, stream,
    input  busy, wr_req, wr_data, done, ovf
  );

  modport slave (
    input  start, int_in, frac_in, stream,
    output busy, wr_req, wr_data, done, ovf
  );

endinterface

// File: rtl/exp_taylor_accel_fx_mul_trunc.sv
// Unsigned fixed-point multiplier: full-width product, then truncating
// right shift by FRAC_W so no intermediate bits are lost before the shift.
module fx_mul_trunc #(
  parameter  int A_W    = 24,
  parameter  int B_W    = 18,
  parameter  int FRAC_W = 16,
  localparam int Y_W    = A_W + B_W - FRAC_W
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [Y_W-1:0] y
);

  logic [A_W+B_W-1:0] prod;

  assign prod = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
  assign y    = Y_W'(prod >> FRAC_W);

endmodule

// File: rtl/exp_taylor_accel.sv
// Sequential e^x evaluator: one Taylor term per three clocks on a single
// shared multiplier, saturating accumulator, registered write/done outputs.
module exp_taylor_accel
  import exp_taylor_pkg::*;
#(
  parameter int INT_W     = 2,
  parameter int FRAC_W    = 16,
  parameter int OUT_INT_W = 6,
  parameter int N_TERMS   = 8
) (
  input logic               clk,
  input logic               rst,
  exp_taylor_accel_if.slave bus
);

  localparam int OUT_W = OUT_INT_W + FRAC_W;
  localparam int X_W   = INT_W + FRAC_W;
  localparam int R_W   = FRAC_W + 1;
  localparam int B_W   = (X_W > R_W) ? X_W : R_W;
  localparam int P_W   = OUT_W + INT_W;
  localparam int M_W   = P_W + B_W - FRAC_W;
  localparam int K_W   = $clog2(N_TERMS);

  localparam logic [OUT_W-1:0] ONE    = OUT_W'(1) << FRAC_W;
  localparam logic [K_W-1:0]   K_LAST = K_W'(N_TERMS - 1);

  if (!n_terms_ok(N_TERMS)) begin : g_bad_n_terms
    $error("exp_taylor_accel: N_TERMS must lie in 2..16");
  end

  logic [R_W-1:0] recip_tab [2**K_W];

  for (genvar i = 0; i < 2**K_W; i++) begin : g_recip
    assign recip_tab[i] = R_W'(recip(i, FRAC_W));
  end

  state_t            state_q, state_n;
  logic [X_W-1:0]    x_q, x_n;
  logic              stream_q, stream_n;
  logic [OUT_W-1:0]  term_q, term_n;
  logic [OUT_W-1:0]  sum_q, sum_n;
  logic [P_W-1:0]    p_q, p_n;
  logic [K_W-1:0]    k_q, k_n;
  logic              busy_q, busy_n;
  logic              wr_req_q, wr_req_n;
  logic [OUT_W-1:0]  wr_data_q, wr_data_n;
  logic              done_q, done_n;
  logic              ovf_q, ovf_n;

  logic [P_W-1:0]    mul_a;
  logic [B_W-1:0]    mul_b;
  logic [M_W-1:0]    mul_y;
  logic [OUT_W:0]    acc;

  fx_mul_trunc #(
    .A_W    (P_W),
    .B_W    (B_W),
    .FRAC_W (FRAC_W)
  ) u_mul (
    .a (mul_a),
    .b (mul_b),
    .y (mul_y)
  );

  always_comb begin
    state_n   = state_q;
    x_n       = x_q;
    stream_n  = stream_q;
    term_n    = term_q;
    sum_n     = sum_q;
    p_n       = p_q;
    k_n       = k_q;
    busy_n    = (state_q != IDLE);
    wr_req_n  = 1'b0;
    wr_data_n = wr_data_q;
    done_n    = 1'b0;
    ovf_n     = ovf_q;
    mul_a     = '0;
    mul_b     = '0;
    acc       = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_n      = {bus.int_in, bus.frac_in};
          stream_n = bus.stream;
          term_n   = ONE;
          sum_n    = ONE;
          k_n      = K_W'(1);
          ovf_n    = 1'b0;
          busy_n   = 1'b1;
          state_n  = MUL_X;
        end
      end
      MUL_X: begin
        mul_a   = P_W'(term_q);
        mul_b   = B_W'(x_q);
        p_n     = mul_y[P_W-1:0];
        state_n = MUL_R;
      end
      // a term too large for the register clamps, which forces the sum to saturate
      MUL_R: begin
        mul_a   = p_q;
        mul_b   = B_W'(recip_tab[k_q]);
        term_n  = (|mul_y[M_W-1:OUT_W]) ? '1 : mul_y[OUT_W-1:0];
        state_n = ACC;
      end
      ACC: begin
        acc = {1'b0, sum_q} + {1'b0, term_q};
        if (acc[OUT_W]) begin
          sum_n = '1;
          ovf_n = 1'b1;
        end else begin
          sum_n = acc[OUT_W-1:0];
        end
        if (stream_q) begin
          wr_req_n  = 1'b1;
          wr_data_n = sum_n;
        end
        if (k_q == K_LAST) begin
          state_n = FIN;
        end else begin
          k_n     = k_q + K_W'(1);
          state_n = MUL_X;
        end
      end
      FIN: begin
        done_n = 1'b1;
        if (!stream_q) begin
          wr_req_n  = 1'b1;
          wr_data_n = sum_q;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      stream_q  <= 1'b0;
      term_q    <= '0;
      sum_q     <= '0;
      p_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      x_q       <= x_n;
      stream_q  <= stream_n;
      term_q    <= term_n;
      sum_q     <= sum_n;
      p_q       <= p_n;
      k_q       <= k_n;
      busy_q    <= busy_n;
      wr_req_q  <= wr_req_n;
      wr_data_q <= wr_data_n;
      done_q    <= done_n;
      ovf_q     <= ovf_n;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.wr_req  = wr_req_q;
  assign bus.wr_data = wr_data_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_exp_taylor_accel.sv
// Directed bench for exp_taylor_accel: a default-width instance and a
// narrow-output (OUT_INT_W=4) instance for the saturation case.
module tb_exp_taylor_accel;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  exp_taylor_accel_if #(.INT_W(2), .FRAC_W(16), .OUT_W(22)) bus_a ();
  exp_taylor_accel_if #(.INT_W(2), .FRAC_W(16), .OUT_W(20)) bus_b ();

  exp_taylor_accel #(.INT_W(2), .FRAC_W(16), .OUT_INT_W(6), .N_TERMS(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  exp_taylor_accel #(.INT_W(2), .FRAC_W(16), .OUT_INT_W(4), .N_TERMS(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int checks = 0;
  int errors = 0;

  logic [21:0] wr_vals[$];
  logic        wr_ovfs[$];
  int          wr_cycles[$];
  int          done_cycles[$];
  int          busy_cycles;

  longint      model_sums[16];
  logic        model_ovf;

  // bit-exact truncating series reference, N_TERMS = 8, FRAC_W = 16
  task automatic run_model(input longint x, input int out_w);
    longint term, sum, p, r, maxv;
    maxv      = (64'sd1 <<< out_w) - 1;
    term      = 65536;
    sum       = 65536;
    model_ovf = 1'b0;
    for (int k = 1; k < 8; k++) begin
      p    = (term * x) >>> 16;
      r    = 65536 / k;
      term = (p * r) >>> 16;
      sum  = sum + term;
      if (sum > maxv) begin
        sum       = maxv;
        model_ovf = 1'b1;
      end
      model_sums[k] = sum;
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic [1:0] ii,
                       input logic [15:0] ff, input logic st);
    if (sel) begin
      bus_b.start = s; bus_b.int_in = ii; bus_b.frac_in = ff; bus_b.stream = st;
    end else begin
      bus_a.start = s; bus_a.int_in = ii; bus_a.frac_in = ff; bus_a.stream = st;
    end
  endtask

  task automatic sample(input bit sel, output logic req, output logic [21:0] data,
                        output logic dn, output logic bsy, output logic ov);
    if (sel) begin
      req = bus_b.wr_req; data = 22'(bus_b.wr_data); dn = bus_b.done;
      bsy = bus_b.busy;   ov = bus_b.ovf;
    end else begin
      req = bus_a.wr_req; data = bus_a.wr_data; dn = bus_a.done;
      bsy = bus_a.busy;   ov = bus_a.ovf;
    end
  endtask

  // one operation over a fixed 40-cycle window; n counts cycles after the start edge
  task automatic run_op(input bit sel, input logic [1:0] ii, input logic [15:0] ff,
                        input logic st);
    logic req, dn, bsy, ov;
    logic [21:0] data;
    wr_vals.delete(); wr_ovfs.delete(); wr_cycles.delete(); done_cycles.delete();
    busy_cycles = 0;
    @(negedge clk);
    drive(sel, 1'b1, ii, ff, st);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) drive(sel, 1'b0, ii, ff, st);
      sample(sel, req, data, dn, bsy, ov);
      if (req) begin
        wr_vals.push_back(data);
        wr_ovfs.push_back(ov);
        wr_cycles.push_back(n);
      end
      if (dn) done_cycles.push_back(n);
      if (bsy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_a.busy, bus_a.wr_req, bus_a.done, bus_a.ovf} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags_a: got %b expected 0000",
               {bus_a.busy, bus_a.wr_req, bus_a.done, bus_a.ovf});
    end
    checks++;
    if (bus_a.wr_data !== 22'h0) begin
      errors++;
      $display("[TB] FAIL reset_data_a: got %h expected 0", bus_a.wr_data);
    end
    checks++;
    if ({bus_b.busy, bus_b.wr_req, bus_b.done, bus_b.ovf} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags_b: got %b expected 0000",
               {bus_b.busy, bus_b.wr_req, bus_b.done, bus_b.ovf});
    end
    checks++;
    if (bus_b.wr_data !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_data_b: got %h expected 0", bus_b.wr_data);
    end
    rst = 1'b1;
  endtask

  task automatic test_zero();
    logic [21:0] v;
    logic        o;
    run_op(1'b0, 2'd0, 16'h0000, 1'b0);
    v = (wr_vals.size() > 0) ? wr_vals[0] : 'x;
    o = (wr_ovfs.size() > 0) ? wr_ovfs[0] : 1'bx;
    checks++;
    if (wr_vals.size() !== 1) begin
      errors++; $display("[TB] FAIL zero_wr_count: got %0d expected 1", wr_vals.size());
    end
    checks++;
    if (v !== 22'h10000) begin
      errors++; $display("[TB] FAIL zero_value: got %h expected 10000", v);
    end
    checks++;
    if (o !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_ovf: got %b expected 0", o);
    end
    checks++;
    if (done_cycles.size() !== 1 || done_cycles[0] !== 23) begin
      errors++;
      $display("[TB] FAIL zero_latency: got %0d dones first at %0d expected 1 at 23",
               done_cycles.size(), (done_cycles.size() > 0) ? done_cycles[0] : -1);
    end
    checks++;
    if (wr_cycles.size() > 0 && wr_cycles[0] !== 23) begin
      errors++; $display("[TB] FAIL zero_wr_cycle: got %0d expected 23", wr_cycles[0]);
    end
    checks++;
    if (busy_cycles !== 23) begin
      errors++; $display("[TB] FAIL zero_busy_len: got %0d expected 23", busy_cycles);
    end
  endtask

  task automatic test_half();
    logic [21:0] v;
    longint      d;
    run_op(1'b0, 2'd0, 16'h8000, 1'b0);
    run_model(64'd32768, 22);
    v = (wr_vals.size() > 0) ? wr_vals[0] : 'x;
    checks++;
    if (wr_vals.size() !== 1) begin
      errors++; $display("[TB] FAIL half_wr_count: got %0d expected 1", wr_vals.size());
    end
    checks++;
    if (v !== 22'(model_sums[7])) begin
      errors++; $display("[TB] FAIL half_model: got %h expected %h", v, 22'(model_sums[7]));
    end
    checks++;
    if (v !== 22'h1A610) begin
      errors++; $display("[TB] FAIL half_hand: got %h expected 1a610", v);
    end
    d = longint'(v) - 64'sh1A612;
    if (d < 0) d = -d;
    checks++;
    if (d > 8) begin
      errors++; $display("[TB] FAIL half_accuracy: got %h expected within 8 of 1a612", v);
    end
    checks++;
    if (done_cycles.size() !== 1 || done_cycles[0] !== 23) begin
      errors++; $display("[TB] FAIL half_done: got %0d dones expected 1 at 23", done_cycles.size());
    end
  endtask

  task automatic test_stream();
    logic [21:0] last;
    logic        mono;
    longint      d;
    int          lastc;
    run_op(1'b0, 2'd0, 16'hC000, 1'b1);
    run_model(64'd49152, 22);
    checks++;
    if (wr_vals.size() !== 7) begin
      errors++; $display("[TB] FAIL stream_wr_count: got %0d expected 7", wr_vals.size());
    end
    for (int i = 0; i < wr_vals.size() && i < 7; i++) begin
      checks++;
      if (wr_vals[i] !== 22'(model_sums[i+1])) begin
        errors++;
        $display("[TB] FAIL stream_partial_%0d: got %h expected %h", i + 1, wr_vals[i],
                 22'(model_sums[i+1]));
      end
    end
    mono = 1'b1;
    for (int i = 1; i < wr_vals.size(); i++) if (wr_vals[i] < wr_vals[i-1]) mono = 1'b0;
    checks++;
    if (mono !== 1'b1) begin
      errors++; $display("[TB] FAIL stream_monotonic: got decreasing sequence expected non-decreasing");
    end
    last  = (wr_vals.size() > 0) ? wr_vals[wr_vals.size()-1] : 'x;
    lastc = (wr_cycles.size() > 0) ? wr_cycles[wr_cycles.size()-1] : -1;
    checks++;
    if (last !== 22'h21DEF) begin
      errors++; $display("[TB] FAIL stream_last_hand: got %h expected 21def", last);
    end
    // ideal e^0.75 in Q.16 is 0x21DF3; truncation loses a few LSB
    d = longint'(last) - 64'sh21DF3;
    if (d < 0) d = -d;
    checks++;
    if (d > 8) begin
      errors++; $display("[TB] FAIL stream_accuracy: got %h expected within 8 of 21df3", last);
    end
    checks++;
    if (done_cycles.size() !== 1 || done_cycles[0] !== lastc + 1 || lastc !== 22) begin
      errors++;
      $display("[TB] FAIL stream_done_after_last: got last strobe %0d dones %0d expected strobe 22 done 23",
               lastc, done_cycles.size());
    end
  endtask

  task automatic test_saturation();
    logic [21:0] v;
    logic        o;
    run_op(1'b1, 2'd3, 16'h0000, 1'b0);
    run_model(64'd196608, 20);
    v = (wr_vals.size() > 0) ? wr_vals[0] : 'x;
    o = (wr_ovfs.size() > 0) ? wr_ovfs[0] : 1'bx;
    checks++;
    if (wr_vals.size() !== 1) begin
      errors++; $display("[TB] FAIL sat_wr_count: got %0d expected 1", wr_vals.size());
    end
    checks++;
    if (v !== 22'h0FFFFF || v !== 22'(model_sums[7])) begin
      errors++; $display("[TB] FAIL sat_value: got %h expected fffff", v);
    end
    checks++;
    if (o !== 1'b1 || model_ovf !== 1'b1) begin
      errors++; $display("[TB] FAIL sat_ovf: got %b expected 1", o);
    end
    run_op(1'b1, 2'd0, 16'h0000, 1'b0);
    v = (wr_vals.size() > 0) ? wr_vals[0] : 'x;
    o = (wr_ovfs.size() > 0) ? wr_ovfs[0] : 1'bx;
    checks++;
    if (v !== 22'h10000) begin
      errors++; $display("[TB] FAIL sat_next_value: got %h expected 10000", v);
    end
    checks++;
    if (o !== 1'b0) begin
      errors++; $display("[TB] FAIL sat_ovf_cleared: got %b expected 0", o);
    end
  endtask

  task automatic test_ignored_start();
    logic req, dn, bsy, ov;
    logic [21:0] data;
    logic busy24;
    wr_vals.delete(); wr_cycles.delete(); done_cycles.delete();
    busy24 = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'd0, 16'h0000, 1'b0);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      sample(1'b0, req, data, dn, bsy, ov);
      if (req) begin wr_vals.push_back(data); wr_cycles.push_back(n); end
      if (dn) done_cycles.push_back(n);
      if (n == 24) busy24 = bsy;
      if (n == 1 || n == 6 || n == 24) drive(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
      if (n == 5)  drive(1'b0, 1'b1, 2'd0, 16'hC000, 1'b1);
      if (n == 22) drive(1'b0, 1'b1, 2'd0, 16'hC000, 1'b0);
      if (n == 23) drive(1'b0, 1'b1, 2'd0, 16'h8000, 1'b0);
    end
    checks++;
    if (wr_vals.size() !== 2) begin
      errors++; $display("[TB] FAIL ign_wr_count: got %0d expected 2", wr_vals.size());
    end
    checks++;
    if (wr_vals.size() > 0 && wr_vals[0] !== 22'h10000) begin
      errors++; $display("[TB] FAIL ign_first_value: got %h expected 10000", wr_vals[0]);
    end
    checks++;
    if (wr_vals.size() > 1 && wr_vals[1] !== 22'h1A610) begin
      errors++; $display("[TB] FAIL ign_second_value: got %h expected 1a610", wr_vals[1]);
    end
    checks++;
    if (done_cycles.size() !== 2 || done_cycles[0] !== 23 || done_cycles[1] !== 46) begin
      errors++;
      $display("[TB] FAIL ign_done_cycles: got %0d dones first %0d expected dones at 23 and 46",
               done_cycles.size(), (done_cycles.size() > 0) ? done_cycles[0] : -1);
    end
    checks++;
    if (busy24 !== 1'b1) begin
      errors++; $display("[TB] FAIL ign_busy_restart: got %b expected 1", busy24);
    end
  endtask

  task automatic test_mid_reset();
    int stray;
    logic [21:0] v;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'd0, 16'h8000, 1'b1);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) drive(1'b0, 1'b0, 2'd0, 16'h8000, 1'b1);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_a.busy, bus_a.wr_req, bus_a.done, bus_a.ovf} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midrst_flags: got %b expected 0000",
               {bus_a.busy, bus_a.wr_req, bus_a.done, bus_a.ovf});
    end
    checks++;
    if (bus_a.wr_data !== 22'h0) begin
      errors++; $display("[TB] FAIL midrst_data: got %h expected 0", bus_a.wr_data);
    end
    rst   = 1'b1;
    stray = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus_a.wr_req === 1'b1 || bus_a.done === 1'b1) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("[TB] FAIL midrst_no_write: got %0d strobes expected 0", stray);
    end
    run_op(1'b0, 2'd0, 16'h8000, 1'b0);
    v = (wr_vals.size() > 0) ? wr_vals[0] : 'x;
    checks++;
    if (wr_vals.size() !== 1 || v !== 22'h1A610) begin
      errors++;
      $display("[TB] FAIL midrst_restart: got %0d writes value %h expected 1 write 1a610",
               wr_vals.size(), v);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_zero();
    test_half();
    test_stream();
    test_saturation();
    test_ignored_start();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
